// File: rtl/ctrl_mac_seq_pkg.sv
// ctrl_mac_seq_pkg
//   Shared definitions for the SRC MAC sequencer: FSM state encodings,
//   regfile access codes {rf_rw, res_err} and the width of the shared
//   DRAIN/RD wait counter.
`timescale 1ns/1ps
package ctrl_mac_seq_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CALC  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_WB    = 3'd4;
    localparam logic [2:0] S_RD    = 3'd5;
    localparam logic [2:0] S_OUT   = 3'd6;

    // {rf_rw, res_err}; on reads res_err is don't-care and driven 0
    localparam logic [1:0] RF_RD     = 2'b10;
    localparam logic [1:0] RF_WR_RES = 2'b01;
    localparam logic [1:0] RF_WR_ERR = 2'b00;

    // Wait counter holds MAC_LAT-1 (max 6) or the single extra RD cycle
    localparam int unsigned WAIT_W = 3;

endpackage

// File: rtl/ctrl_step_cnt.sv
// ctrl_step_cnt
//   Loadable down-counter with terminal flag. Saturates at zero.
// Ports
//   i_clk       clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_en        global enable; counter holds when 0
//   i_load      load i_load_val (has priority over i_dec)
//   i_load_val  value to load
//   i_dec       decrement by one
//   o_count     current count
//   o_last      count is zero
`timescale 1ns/1ps
module ctrl_step_cnt
    import ctrl_mac_seq_pkg::*;
#(
    parameter int unsigned W = WAIT_W
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic [W-1:0] o_count,
    output logic         o_last
);

    logic [W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (i_load) begin
                r_count <= i_load_val;
            end else if (i_dec && (r_count != '0)) begin
                r_count <= r_count - W'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == '0);

endmodule

// File: rtl/ctrl_mac_seq.sv
// ctrl_mac_seq
//   Sequencer for one output sample of the SRC filter loop: writes the input
//   sample to the regfile, walks NTAPS taps through the MAC, waits out the MAC
//   pipeline, writes the result back, reads it out and presents it.
// Ports
//   clk, rst            clock / asynchronous active-low reset
//   en                  global enable; everything holds when 0
//   in_valid/in_ready   input sample handshake
//   out_valid/out_ready result handshake
//   busy                high in every state except IDLE
//   rf_en, rf_rw, res_err, get_reg, result_reg, error_reg  regfile address driver
//   mac_clr, mac_en     MAC control
`timescale 1ns/1ps
module ctrl_mac_seq
    import ctrl_mac_seq_pkg::*;
#(
    parameter int unsigned WIDTH    = 3,
    parameter int unsigned NTAPS    = 4,
    parameter int unsigned MAC_LAT  = 2,
    parameter int unsigned TAP_BASE = 0,
    parameter int unsigned ERR_REG  = 6,
    parameter int unsigned RES_REG  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             rf_en,
    output logic             rf_rw,
    output logic             res_err,
    output logic             get_reg,
    output logic [WIDTH-1:0] result_reg,
    output logic [WIDTH-1:0] error_reg,
    output logic             mac_clr,
    output logic             mac_en
);

    generate
        if (NTAPS < 1 || NTAPS > (1 << WIDTH) - 2 || MAC_LAT > 7 ||
            (ERR_REG >= TAP_BASE && ERR_REG <= TAP_BASE + NTAPS - 1) ||
            (RES_REG >= TAP_BASE && RES_REG <= TAP_BASE + NTAPS - 1)) begin : g_bad_params
            $error("ctrl_mac_seq: illegal parameter set");
        end
    endgenerate

    localparam int unsigned TC_W = $clog2(NTAPS) + 1;

    localparam logic [TC_W-1:0]   TAP_LD   = TC_W'(NTAPS - 1);
    localparam logic [TC_W-1:0]   NTAPS_T  = TC_W'(NTAPS);
    localparam logic [WAIT_W-1:0] DRAIN_LD = WAIT_W'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);
    localparam logic [WAIT_W-1:0] RD_LD    = WAIT_W'(1);
    localparam logic [WIDTH-1:0]  A_TAP0   = WIDTH'(TAP_BASE);
    localparam logic [WIDTH-1:0]  A_ERR    = WIDTH'(ERR_REG);
    localparam logic [WIDTH-1:0]  A_RES    = WIDTH'(RES_REG);

    logic [2:0]        r_state;
    logic [2:0]        w_next_state;
    logic              w_accept;

    logic              w_tap_load, w_tap_dec, w_tap_last;
    logic [TC_W-1:0]   w_tap_cnt, w_tap_idx;
    logic              w_wait_load, w_wait_dec, w_wait_last;
    logic [WAIT_W-1:0] w_wait_ld_val, w_wait_cnt;

    logic              w_nx_rf_en, w_nx_get, w_nx_clr, w_nx_mac_en, w_nx_ov;
    logic [1:0]        w_nx_acc;
    logic [WIDTH-1:0]  w_nx_result, w_nx_error;

    // in_ready must answer in_valid in the same cycle, so it is decoded from
    // registered state rather than registered itself; gated by rst so it reads
    // 0 during reset like every other output.
    assign w_accept = rst && en && in_valid &&
                      ((r_state == S_IDLE) || ((r_state == S_OUT) && out_ready));
    assign in_ready = w_accept;

    // The counter holds "taps still to issue after the current one"
    assign w_tap_idx = NTAPS_T - w_tap_cnt;

    ctrl_step_cnt #(.W(TC_W)) u_tap_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_en       (en),
        .i_load     (w_tap_load),
        .i_load_val (TAP_LD),
        .i_dec      (w_tap_dec),
        .o_count    (w_tap_cnt),
        .o_last     (w_tap_last)
    );

    ctrl_step_cnt #(.W(WAIT_W)) u_wait_cnt (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_en       (en),
        .i_load     (w_wait_load),
        .i_load_val (w_wait_ld_val),
        .i_dec      (w_wait_dec),
        .o_count    (w_wait_cnt),
        .o_last     (w_wait_last)
    );

    always_comb begin
        w_next_state  = r_state;
        w_tap_load    = 1'b0;
        w_tap_dec     = 1'b0;
        w_wait_load   = 1'b0;
        w_wait_dec    = 1'b0;
        w_wait_ld_val = DRAIN_LD;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next_state = S_LOAD;
            S_LOAD: begin
                w_next_state = S_CALC;
                w_tap_load   = 1'b1;
            end
            S_CALC: begin
                if (w_tap_last) begin
                    if (MAC_LAT != 0) begin
                        w_next_state = S_DRAIN;
                        w_wait_load  = 1'b1;
                    end else begin
                        w_next_state = S_WB;
                    end
                end else begin
                    w_tap_dec = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_wait_last) w_next_state = S_WB;
                else             w_wait_dec   = 1'b1;
            end
            S_WB: begin
                w_next_state  = S_RD;
                w_wait_load   = 1'b1;
                w_wait_ld_val = RD_LD;
            end
            S_RD: begin
                if (w_wait_cnt == '0) w_next_state = S_OUT;
                else                  w_wait_dec   = 1'b1;
            end
            S_OUT: if (out_ready) w_next_state = w_accept ? S_LOAD : S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so the registered
    // strobes line up with the state they belong to.
    always_comb begin
        w_nx_rf_en  = 1'b0;
        w_nx_acc    = RF_WR_ERR;
        w_nx_get    = 1'b0;
        w_nx_clr    = 1'b0;
        w_nx_mac_en = 1'b0;
        w_nx_ov     = 1'b0;
        w_nx_result = result_reg;
        w_nx_error  = error_reg;
        unique case (w_next_state)
            S_LOAD: begin
                w_nx_rf_en = 1'b1;
                w_nx_acc   = RF_WR_ERR;
                w_nx_error = A_ERR;
            end
            S_CALC: begin
                w_nx_rf_en  = 1'b1;
                w_nx_acc    = RF_RD;
                w_nx_error  = A_ERR;
                w_nx_mac_en = 1'b1;
                if (r_state == S_LOAD) begin
                    w_nx_clr    = 1'b1;
                    w_nx_result = A_TAP0;
                end else begin
                    w_nx_result = A_TAP0 + WIDTH'(w_tap_idx);
                end
            end
            S_WB: begin
                w_nx_rf_en  = 1'b1;
                w_nx_acc    = RF_WR_RES;
                w_nx_result = A_RES;
            end
            S_RD: begin
                // Only the first RD cycle issues the read; the second just waits
                if (r_state == S_WB) begin
                    w_nx_rf_en  = 1'b1;
                    w_nx_acc    = RF_RD;
                    w_nx_get    = 1'b1;
                    w_nx_result = A_RES;
                end
            end
            S_OUT: w_nx_ov = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            busy       <= 1'b0;
            rf_en      <= 1'b0;
            rf_rw      <= 1'b0;
            res_err    <= 1'b0;
            get_reg    <= 1'b0;
            mac_clr    <= 1'b0;
            mac_en     <= 1'b0;
            out_valid  <= 1'b0;
            result_reg <= '0;
            error_reg  <= '0;
        end else if (en) begin
            r_state          <= w_next_state;
            busy             <= (w_next_state != S_IDLE);
            rf_en            <= w_nx_rf_en;
            {rf_rw, res_err} <= w_nx_acc;
            get_reg          <= w_nx_get;
            mac_clr          <= w_nx_clr;
            mac_en           <= w_nx_mac_en;
            out_valid        <= w_nx_ov;
            result_reg       <= w_nx_result;
            error_reg        <= w_nx_error;
        end
    end

endmodule

// File: tb/tb_ctrl_mac_seq.sv
`timescale 1ns/1ps
module tb_ctrl_mac_seq;

    localparam int unsigned LAT0   = 11;  // 5 + NTAPS(4) + MAC_LAT(2)
    localparam int unsigned LAT1   = 6;   // 5 + NTAPS(1) + MAC_LAT(0)
    localparam int unsigned BUDGET = 200;

    // {busy, rf_en, rf_rw, res_err, get_reg, mac_clr, mac_en, out_valid, result_reg, error_reg}
    localparam logic [13:0] TR0 [12] = '{
        14'b11000000_000_110,  // LOAD
        14'b11100110_000_110,  // CALC tap0 (clr)
        14'b11100010_001_110,  // CALC tap1
        14'b11100010_010_110,  // CALC tap2
        14'b11100010_011_110,  // CALC tap3
        14'b10000000_011_110,  // DRAIN
        14'b10000000_011_110,  // DRAIN
        14'b11010000_111_110,  // WB
        14'b11101000_111_110,  // RD issue
        14'b10000000_111_110,  // RD wait
        14'b10000001_111_110,  // OUT
        14'b00000000_111_110   // IDLE
    };
    localparam logic [13:0] TR1 [7] = '{
        14'b11000000_000_110,  // LOAD
        14'b11100110_000_110,  // CALC tap0 (clr)
        14'b11010000_111_110,  // WB
        14'b11101000_111_110,  // RD issue
        14'b10000000_111_110,  // RD wait
        14'b10000001_111_110,  // OUT
        14'b00000000_111_110   // IDLE
    };

    logic       clk = 1'b0;
    logic       rst, en;
    logic       in_valid, in_ready, out_valid, out_ready, busy;
    logic       rf_en, rf_rw, res_err, get_reg, mac_clr, mac_en;
    logic [2:0] result_reg, error_reg;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, busy1;
    logic       rf_en1, rf_rw1, res_err1, get_reg1, mac_clr1, mac_en1;
    logic [2:0] result_reg1, error_reg1;

    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int unsigned q0[$];
    int unsigned q1[$];
    logic        ov0_d = 1'b0;
    logic        ov1_d = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ctrl_mac_seq dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
        .rf_en(rf_en), .rf_rw(rf_rw), .res_err(res_err), .get_reg(get_reg),
        .result_reg(result_reg), .error_reg(error_reg),
        .mac_clr(mac_clr), .mac_en(mac_en)
    );

    ctrl_mac_seq #(.NTAPS(1), .MAC_LAT(0)) dut1 (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .out_valid(out_valid1), .out_ready(out_ready1), .busy(busy1),
        .rf_en(rf_en1), .rf_rw(rf_rw1), .res_err(res_err1), .get_reg(get_reg1),
        .result_reg(result_reg1), .error_reg(error_reg1),
        .mac_clr(mac_clr1), .mac_en(mac_en1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [13:0] vec0();
        return {busy, rf_en, rf_rw, res_err, get_reg, mac_clr, mac_en, out_valid, result_reg, error_reg};
    endfunction

    function automatic logic [13:0] vec1();
        return {busy1, rf_en1, rf_rw1, res_err1, get_reg1, mac_clr1, mac_en1, out_valid1, result_reg1, error_reg1};
    endfunction

    // Scoreboard: each accepted sample queued the cycle its out_valid must rise
    always @(negedge clk) begin
        int unsigned e;
        if (out_valid && !ov0_d) begin
            e = (q0.size() != 0) ? q0.pop_front() : 32'hFFFF_FFFF;
            check("sb0_out_cycle", 32'(cyc), 32'(e));
        end
        if (out_valid1 && !ov1_d) begin
            e = (q1.size() != 0) ? q1.pop_front() : 32'hFFFF_FFFF;
            check("sb1_out_cycle", 32'(cyc), 32'(e));
        end
        ov0_d <= out_valid;
        ov1_d <= out_valid1;
    end

    // Called just after a negedge with in_valid already driven
    task automatic accept(input bit sel, input int unsigned adj, output int unsigned t);
        int unsigned n = 0;
        logic ok;
        #1;
        ok = sel ? in_ready1 : in_ready;
        while (!ok && n < BUDGET) begin
            @(negedge clk); #1;
            n++;
            ok = sel ? in_ready1 : in_ready;
        end
        check(sel ? "acc1_wait" : "acc0_wait", 32'(ok), 32'(1));
        t = cyc;
        if (ok) begin
            if (sel) q1.push_back(cyc + LAT1 + adj);
            else     q0.push_back(cyc + LAT0 + adj);
        end
    endtask

    task automatic send0(input int unsigned adj);
        int unsigned t;
        in_valid = 1'b1;
        accept(1'b0, adj, t);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic trace0(input string tag);
        for (int k = 0; k < 12; k++) begin
            #1 check($sformatf("%s[%0d]", tag, k + 1), 32'(vec0()), 32'(TR0[k]));
            @(negedge clk);
        end
    endtask

    task automatic drain(input bit sel);
        int unsigned n = 0;
        while ((sel ? (q1.size() != 0 || busy1) : (q0.size() != 0 || busy)) && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check(sel ? "drain1" : "drain0", 32'(sel ? q1.size() : q0.size()), 32'(0));
    endtask

    initial begin
        int unsigned t0, t1;
        logic [13:0] snap;
        rst = 1'b1; en = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1;
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("reset_outs0", 32'({in_ready, vec0()}), 32'(0));
        check("reset_outs1", 32'({in_ready1, vec1()}), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single sample, full strobe trace
        send0(0);
        trace0("t2_trace");

        // Reset during CALC tap 2, then a clean sample
        send0(0);
        repeat (3) @(negedge clk);
        #1 check("t1_tap2", 32'(result_reg), 32'(2));
        rst = 1'b0;
        #1 check("t1_rst_outs", 32'({in_ready, vec0()}), 32'(0));
        q0.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check("t1_idle", 32'(busy), 32'(0));
        @(negedge clk);
        send0(0);
        trace0("t1_trace");

        // Back-pressure: out_ready low for 5 OUT cycles
        out_ready = 1'b0;
        send0(0);
        for (int k = 1; k <= 10; k++) begin
            in_valid = k[0];
            #1 check("t3_in_ready_busy", 32'(in_ready), 32'(0));
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            #1 check("t3_out_valid_held", 32'(out_valid), 32'(1));
            check("t3_rf_en_quiet", 32'(rf_en), 32'(0));
            if (k == 4) out_ready = 1'b1;
            @(negedge clk);
        end
        #1 check("t3_after_hs", 32'({out_valid, busy}), 32'(0));
        @(negedge clk);

        // Back-to-back with in_valid held
        in_valid = 1'b1;
        accept(1'b0, 0, t0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1 check("t4_load", 32'({busy, rf_en, rf_rw, res_err, error_reg}), 32'(7'b1_100_110));
            accept(1'b0, 0, t1);
            check("t4_out_inready", 32'(out_valid), 32'(1));
            check("t4_period", 32'(t1 - t0), 32'(LAT0));
            t0 = t1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        drain(1'b0);

        // en low for 3 cycles at CALC tap 1
        in_valid = 1'b1;
        accept(1'b0, 3, t0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #1 check("t5_tap1", 32'({result_reg, mac_en, mac_clr}), 32'(5'b001_1_0));
        snap = vec0();
        en = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1 check("t5_frozen", 32'(vec0()), 32'(snap));
        end
        en = 1'b1;
        @(negedge clk);
        #1 check("t5_tap2", 32'(result_reg), 32'(2));
        drain(1'b0);

        // NTAPS=1, MAC_LAT=0 instance
        in_valid1 = 1'b1;
        accept(1'b1, 0, t0);
        @(negedge clk);
        in_valid1 = 1'b0;
        for (int k = 0; k < 7; k++) begin
            #1 check($sformatf("t6_trace[%0d]", k + 1), 32'(vec1()), 32'(TR1[k]));
            @(negedge clk);
        end
        drain(1'b1);

        check("sb0_empty", 32'(q0.size()), 32'(0));
        check("sb1_empty", 32'(q1.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
